// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/forwarding control with mult/div latency tracking and a saturating stall counter
module hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             MultDivD,
  input  logic             HiLoReadD,
  input  logic             MultDivStartE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MdBusy,
  output logic [CNT_W-1:0] StallCount
);
  logic [7:0]       r_md_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_md_pend, w_lwstall, w_brstall, w_mdstall, w_stall;
  logic [1:0]       w_fae, w_fbe;
  always_comb begin
    w_md_pend = r_md_cnt != 8'd0;
    w_lwstall = MemtoRegE & (RtE == RsD | RtE == RtD);
    w_brstall = BranchD & ((RegWriteE & (WriteRegE == RsD | WriteRegE == RtD)) |
                           (MemtoRegM & (WriteRegM == RsD | WriteRegM == RtD)));
    w_mdstall = (MultDivD | HiLoReadD) & (MultDivStartE | w_md_pend);
    w_stall   = ~reset & (w_lwstall | w_brstall | w_mdstall);
    w_fae = (RsE != 5'd0 && RsE == WriteRegM && RegWriteM) ? 2'b10 :
            (RsE != 5'd0 && RsE == WriteRegW && RegWriteW) ? 2'b01 : 2'b00;
    w_fbe = (RtE != 5'd0 && RtE == WriteRegM && RegWriteM) ? 2'b10 :
            (RtE != 5'd0 && RtE == WriteRegW && RegWriteW) ? 2'b01 : 2'b00;
  end
  assign StallF     = w_stall;
  assign StallD     = w_stall;
  assign FlushE     = reset | w_stall;
  assign ForwardAE  = reset ? 2'b00 : w_fae;
  assign ForwardBE  = reset ? 2'b00 : w_fbe;
  assign ForwardAD  = ~reset & RsD != 5'd0 & RsD == WriteRegM & RegWriteM;
  assign ForwardBD  = ~reset & RtD != 5'd0 & RtD == WriteRegM & RegWriteM;
  assign MdBusy     = ~reset & w_md_pend;
  assign StallCount = r_stall_cnt;
  // a new issue reloads the counter even if a previous result is still pending
  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_cnt    <= 8'd0;
      r_stall_cnt <= '0;
    end else begin
      r_md_cnt    <= MultDivStartE ? 8'(MD_LATENCY - 1) : w_md_pend ? r_md_cnt - 8'd1 : 8'd0;
      r_stall_cnt <= (w_stall && r_stall_cnt != '1) ? r_stall_cnt + 1'b1 : r_stall_cnt;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random stimulus scored against a cycle-indexed reference model
module tb_hazard_ctrl;
  localparam int MDL = 4;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic BranchD, MultDivD, HiLoReadD, MultDivStartE;
  logic StallF, StallD, FlushE, ForwardAD, ForwardBD, MdBusy;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CW-1:0] StallCount;
  typedef struct {
    logic sf, sd, fe, fad, fbd, busy;
    logic [1:0] fae, fbe;
    int cnt;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  int cyc = 0, last_issue = -1000, cnt = 0;
  logic p_reset = 1'b1, p_start = 1'b0, p_stall = 1'b0;
  hazard_ctrl #(.MD_LATENCY(MDL), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MultDivD(MultDivD), .HiLoReadD(HiLoReadD), .MultDivStartE(MultDivStartE),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .ForwardAD(ForwardAD),
    .ForwardBD(ForwardBD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MdBusy(MdBusy), .StallCount(StallCount)
  );
  always #5 clk = ~clk;
  function automatic logic [1:0] fwd_e(logic [4:0] r);
    if (r != 0 && r == WriteRegM && RegWriteM) return 2'b10;
    if (r != 0 && r == WriteRegW && RegWriteW) return 2'b01;
    return 2'b00;
  endfunction
  task automatic clr();
    reset = 0; RsD = 0; RtD = 0; RsE = 0; RtE = 0; WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; MemtoRegM = 0;
    BranchD = 0; MultDivD = 0; HiLoReadD = 0; MultDivStartE = 0;
  endtask
  // advance the model across the edge that just happened, then release inputs for the new cycle
  task automatic begin_cycle();
    @(posedge clk);
    cyc++;
    if (p_reset) begin
      last_issue = -1000;
      cnt = 0;
    end else begin
      if (p_start) last_issue = cyc - 1;
      if (p_stall && cnt < CMAX) cnt++;
    end
    #1;
    clr();
  endtask
  task automatic end_cycle();
    exp_t e;
    logic busy, lw, br, md, st;
    busy = !reset && (cyc - last_issue) >= 1 && (cyc - last_issue) < MDL;
    lw = MemtoRegE && (RtE == RsD || RtE == RtD);
    br = BranchD && ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                     (MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)));
    md = (MultDivD || HiLoReadD) && (MultDivStartE || busy);
    st = !reset && (lw || br || md);
    e.sf = st; e.sd = st; e.fe = reset || st; e.busy = busy; e.cnt = cnt;
    e.fae = reset ? 2'b00 : fwd_e(RsE);
    e.fbe = reset ? 2'b00 : fwd_e(RtE);
    e.fad = !reset && RsD != 0 && RsD == WriteRegM && RegWriteM;
    e.fbd = !reset && RtD != 0 && RtD == WriteRegM && RegWriteM;
    q.push_back(e);
    p_reset = reset; p_start = MultDivStartE; p_stall = st;
  endtask
  task automatic chk(string n, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", n, cyc, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("StallF", int'(StallF), int'(e.sf));
      chk("StallD", int'(StallD), int'(e.sd));
      chk("FlushE", int'(FlushE), int'(e.fe));
      chk("ForwardAD", int'(ForwardAD), int'(e.fad));
      chk("ForwardBD", int'(ForwardBD), int'(e.fbd));
      chk("ForwardAE", int'(ForwardAE), int'(e.fae));
      chk("ForwardBE", int'(ForwardBE), int'(e.fbe));
      chk("MdBusy", int'(MdBusy), int'(e.busy));
      chk("StallCount", int'(StallCount), e.cnt);
    end
  end
  initial begin
    clr();
    reset = 1;
    repeat (2) begin begin_cycle(); reset = 1; end_cycle(); end
    begin_cycle(); RegWriteM = 1; WriteRegM = 5; RegWriteW = 1; WriteRegW = 5; RsE = 5; RtE = 5; end_cycle();
    begin_cycle(); RegWriteM = 1; WriteRegM = 5; RegWriteW = 1; WriteRegW = 5; end_cycle();
    begin_cycle(); RegWriteW = 1; WriteRegW = 6; RsE = 6; RtE = 6; end_cycle();
    begin_cycle(); MemtoRegE = 1; RtE = 8; RsD = 8; end_cycle();
    begin_cycle(); end_cycle();
    begin_cycle(); BranchD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3; end_cycle();
    begin_cycle(); BranchD = 1; RsD = 3; RegWriteM = 1; WriteRegM = 3; end_cycle();
    begin_cycle(); MultDivStartE = 1; HiLoReadD = 1; end_cycle();
    repeat (5) begin begin_cycle(); HiLoReadD = 1; end_cycle(); end
    begin_cycle(); MultDivStartE = 1; MultDivD = 1; end_cycle();
    begin_cycle(); reset = 1; HiLoReadD = 1; end_cycle();
    repeat (3) begin begin_cycle(); HiLoReadD = 1; end_cycle(); end
    repeat (20) begin begin_cycle(); MemtoRegE = 1; RtE = 9; RtD = 9; end_cycle(); end
    repeat (600) begin
      begin_cycle();
      reset = ($urandom_range(0, 39) == 0);
      RsD = 5'($urandom_range(0, 7)); RtD = 5'($urandom_range(0, 7));
      RsE = 5'($urandom_range(0, 7)); RtE = 5'($urandom_range(0, 7));
      WriteRegE = 5'($urandom_range(0, 7)); WriteRegM = 5'($urandom_range(0, 7));
      WriteRegW = 5'($urandom_range(0, 7));
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = ($urandom_range(0, 3) == 0); MemtoRegM = ($urandom_range(0, 3) == 0);
      BranchD = ($urandom_range(0, 3) == 0);
      MultDivD = ($urandom_range(0, 5) == 0); HiLoReadD = ($urandom_range(0, 3) == 0);
      MultDivStartE = ($urandom_range(0, 9) == 0);
      end_cycle();
    end
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
